// File: rtl/sata_phy_pkg.sv
// Shared state encoding and OOB timing constants for the SATA link bring-up
// sequencer and the PHY wrapper it drives.
package sata_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_PLL  = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_LINK = 3'd4,
        ST_LINKED    = 3'd5,
        ST_HOLDOFF   = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    // OOB burst/gap timing in UI, shared with the PHY wrapper.
    localparam int unsigned OOB_BURST_UI      = 160;
    localparam int unsigned OOB_COMINIT_GAP   = 480;
    localparam int unsigned OOB_COMWAKE_GAP   = 160;
    localparam int unsigned OOB_BURST_COUNT   = 6;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? 4'hF : v + 4'd1;
    endfunction

endpackage

// File: rtl/sata_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level, resets to 0.
module sata_sync_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sata_phy_link_ctrl.sv
// Per-port SATA PHY link bring-up sequencer with retry/holdoff.
// Define SATA_PHY_LINK_CTRL_STATS_EN to add drop_cnt/attempt_cnt outputs.
module sata_phy_link_ctrl
    import sata_phy_pkg::*;
#(
    parameter int C_RESET_CYCLES   = 64,
    parameter int C_PLL_TIMEOUT    = 4096,
    parameter int C_LINK_TIMEOUT   = 750000,
    parameter int C_HOLDOFF_CYCLES = 1024,
    parameter int C_RETRY_MAX      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        port_en,
    input  logic        plllock,
    input  logic        linkup,
    input  logic        comm_init,
    output logic        phyreset,
    output logic        start_comm,
    output logic        link_ready,
    output logic        link_fail,
    output logic [3:0]  retry_cnt,
`ifdef SATA_PHY_LINK_CTRL_STATS_EN
    output logic [15:0] drop_cnt,
    output logic [15:0] attempt_cnt,
`endif
    output logic [2:0]  ctrl_state
);

    localparam int MAX_A   = (C_RESET_CYCLES > C_PLL_TIMEOUT)
                             ? C_RESET_CYCLES : C_PLL_TIMEOUT;
    localparam int MAX_B   = (C_LINK_TIMEOUT > C_HOLDOFF_CYCLES)
                             ? C_LINK_TIMEOUT : C_HOLDOFF_CYCLES;
    localparam int TMR_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] LD_RESET   = TMR_W'(C_RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_PLL     = TMR_W'(C_PLL_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LD_LINK    = TMR_W'(C_LINK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LD_HOLDOFF = TMR_W'(C_HOLDOFF_CYCLES - 1);

    localparam int         RETRY_CLAMP = (C_RETRY_MAX > 15) ? 15 : C_RETRY_MAX;
    localparam logic [3:0] RETRY_LIM   = 4'(RETRY_CLAMP);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             phyreset_q, phyreset_d;
    logic             start_comm_q, start_comm_d;
    logic             link_ready_q, link_ready_d;
    logic             link_fail_q, link_fail_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic [3:0]       retry_inc;
    logic             attempt_fail;
    logic             tmr_zero;
    logic             pll_ok;

    sata_sync_bit u_pll_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (plllock),
        .q     (pll_ok)
    );

    assign tmr_zero  = (tmr_q == '0);
    assign retry_inc = sat_inc4(retry_cnt_q);

    function automatic logic [TMR_W-1:0] tmr_load(input state_t s);
        unique case (s)
            ST_RESET:     return LD_RESET;
            ST_WAIT_PLL:  return LD_PLL;
            ST_WAIT_LINK: return LD_LINK;
            ST_HOLDOFF:   return LD_HOLDOFF;
            default:      return '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            phyreset_q   <= 1'b1;
            start_comm_q <= 1'b0;
            link_ready_q <= 1'b0;
            link_fail_q  <= 1'b0;
            retry_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            phyreset_q   <= phyreset_d;
            start_comm_q <= start_comm_d;
            link_ready_q <= link_ready_d;
            link_fail_q  <= link_fail_d;
            retry_cnt_q  <= retry_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        attempt_fail = 1'b0;
        if (!port_en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:      state_d = ST_RESET;
                ST_RESET:     if (tmr_zero) state_d = ST_WAIT_PLL;
                ST_WAIT_PLL: begin
                    if (pll_ok)        state_d = ST_START;
                    else if (tmr_zero) attempt_fail = 1'b1;
                end
                ST_START: begin
                    if (!pll_ok) attempt_fail = 1'b1;
                    else         state_d = ST_WAIT_LINK;
                end
                // linkup beats a same-cycle timeout
                ST_WAIT_LINK: begin
                    if (!pll_ok)       attempt_fail = 1'b1;
                    else if (linkup)   state_d = ST_LINKED;
                    else if (tmr_zero) attempt_fail = 1'b1;
                end
                ST_LINKED: begin
                    if (!pll_ok)                   attempt_fail = 1'b1;
                    else if (!linkup || comm_init) state_d = ST_HOLDOFF;
                end
                ST_HOLDOFF:   if (tmr_zero) state_d = ST_RESET;
                ST_FAIL:      state_d = ST_FAIL;
                default:      state_d = ST_IDLE;
            endcase
            if (attempt_fail) begin
                if (RETRY_LIM != 4'd0 && retry_inc >= RETRY_LIM)
                    state_d = ST_FAIL;
                else
                    state_d = ST_HOLDOFF;
            end
        end

        if (state_d != state_q) tmr_d = tmr_load(state_d);
        else if (!tmr_zero)     tmr_d = tmr_q - 1'b1;
        else                    tmr_d = tmr_q;
    end

    always_comb begin
        phyreset_d   = state_d inside {ST_IDLE, ST_RESET, ST_HOLDOFF, ST_FAIL};
        start_comm_d = (state_d == ST_START);
        link_ready_d = (state_d == ST_LINKED);
        link_fail_d  = (state_d == ST_FAIL);
        retry_cnt_d  = retry_cnt_q;
        if (state_d == ST_IDLE || state_d == ST_LINKED)
            retry_cnt_d = 4'd0;
        else if (attempt_fail)
            retry_cnt_d = retry_inc;
    end

`ifdef SATA_PHY_LINK_CTRL_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [15:0] attempt_cnt_q, attempt_cnt_d;

    always_comb begin
        drop_cnt_d    = drop_cnt_q;
        attempt_cnt_d = attempt_cnt_q;
        if (state_q == ST_LINKED && state_d == ST_HOLDOFF && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
        if (state_q != ST_START && state_d == ST_START && attempt_cnt_q != 16'hFFFF)
            attempt_cnt_d = attempt_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q    <= 16'd0;
            attempt_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q    <= drop_cnt_d;
            attempt_cnt_q <= attempt_cnt_d;
        end
    end

    assign drop_cnt    = drop_cnt_q;
    assign attempt_cnt = attempt_cnt_q;
`endif

    assign phyreset   = phyreset_q;
    assign start_comm = start_comm_q;
    assign link_ready = link_ready_q;
    assign link_fail  = link_fail_q;
    assign retry_cnt  = retry_cnt_q;
    assign ctrl_state = state_q;

endmodule
